// File: rtl/sr_window_ctrl.sv
// Sequencer for the parallel-out shift-register chain that builds KERNEL x KERNEL
// conv windows over a raster pixel stream; tracks position and flags valid windows.
module sr_window_ctrl #(
  parameter int IMG_W  = 28,
  parameter int IMG_H  = 28,
  parameter int KERNEL = 5,
  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1,
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          start,
  input  logic [7:0]    pix_in,
  input  logic          pix_valid,
  output logic          pix_ready,
  output logic [7:0]    sr_shift_in,
  output logic          sr_shift_en,
  output logic          win_valid,
  input  logic          win_ready,
  output logic [CW-1:0] win_col,
  output logic [RW-1:0] win_row,
  output logic          busy,
  output logic          frame_done
);

  typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic          accept, last_pix, col_last, win_hit;

  assign col_last = (col == CW'(IMG_W - 1));
  assign last_pix = col_last && (row == RW'(IMG_H - 1));
  // A pending, unconsumed window freezes the chain so its taps stay stable.
  assign pix_ready   = (state == LOAD) && !(win_valid && !win_ready);
  assign accept      = pix_valid && pix_ready;
  assign sr_shift_in = pix_in;
  assign sr_shift_en = accept;
  assign win_hit     = accept && (int'(col) >= KERNEL - 1) && (int'(row) >= KERNEL - 1);
  assign busy        = (state != IDLE);
  assign frame_done  = (state == DONE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = LOAD;
      LOAD:    if (accept && last_pix) state_nxt = DRAIN;
      DRAIN:   if (!win_valid || win_ready) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      col <= '0;
      row <= '0;
    end else if (state == DONE) begin
      col <= '0;
      row <= '0;
    end else if (accept) begin
      if (col_last) begin
        col <= '0;
        row <= last_pix ? '0 : row + RW'(1);
      end else begin
        col <= col + CW'(1);
      end
    end
  end

  // New window may replace a window consumed on the same edge: no bubble.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      win_valid <= 1'b0;
      win_col   <= '0;
      win_row   <= '0;
    end else if (win_hit) begin
      win_valid <= 1'b1;
      win_col   <= col - CW'(KERNEL - 1);
      win_row   <= row - RW'(KERNEL - 1);
    end else if (win_ready) begin
      win_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sr_window_ctrl.sv
// Scoreboard bench for sr_window_ctrl at 6x5 image, 3x3 kernel: driver pushes
// expected window coordinates on each accepted pixel, monitor pops on consume.
module tb_sr_window_ctrl;
  localparam int W = 6, H = 5, K = 3;
  localparam int NPIX = W * H;
  localparam int NWIN = (W - K + 1) * (H - K + 1);

  logic       clock, reset, start, pix_valid, win_ready;
  logic [7:0] pix_in, sr_shift_in;
  logic       pix_ready, sr_shift_en, win_valid, busy, frame_done;
  logic [2:0] win_col, win_row;

  sr_window_ctrl #(.IMG_W(W), .IMG_H(H), .KERNEL(K)) dut (
    .clock(clock), .reset(reset), .start(start), .pix_in(pix_in),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .sr_shift_in(sr_shift_in),
    .sr_shift_en(sr_shift_en), .win_valid(win_valid), .win_ready(win_ready),
    .win_col(win_col), .win_row(win_row), .busy(busy), .frame_done(frame_done));

  int total = 0, bad = 0;
  int win_cnt, shift_cnt, done_cnt;
  int exp_q[$];
  logic stall_req = 1'b0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    start = 1'b0;
  endtask

  // Monitor: scoreboard pops on consume, hold stability, event counters.
  initial begin
    logic held;
    int hc, hr, e;
    held = 1'b0;
    forever begin
      @(negedge clock);
      if (!reset) begin
        held = 1'b0;
      end else begin
        if (sr_shift_en) begin
          shift_cnt++;
          chk("shift_data", int'(sr_shift_in), int'(pix_in));
        end
        if (frame_done) done_cnt++;
        if (held) begin
          chk("hold_valid", int'(win_valid), 1);
          chk("hold_coord", int'(win_col) * 16 + int'(win_row), hc * 16 + hr);
        end
        if (win_valid && win_ready) begin
          win_cnt++;
          if (exp_q.size() == 0) begin
            chk("unexpected_window", int'(win_col) * 16 + int'(win_row), -1);
          end else begin
            e = exp_q.pop_front();
            chk("window_coord", int'(win_col) * 16 + int'(win_row), e);
          end
        end
        held = win_valid && !win_ready;
        hc = int'(win_col);
        hr = int'(win_row);
      end
    end
  end

  // Stall responder: on the first window after a request, withhold win_ready 5 cycles.
  initial begin
    win_ready = 1'b1;
    forever begin
      @(posedge clock);
      #1;
      if (stall_req && win_valid) begin
        stall_req = 1'b0;
        win_ready = 1'b0;
        repeat (5) begin
          @(negedge clock);
          chk("stall_pix_ready", int'(pix_ready), 0);
          chk("stall_shift_en", int'(sr_shift_en), 0);
        end
        @(posedge clock);
        #1;
        win_ready = 1'b1;
      end
    end
  end

  // gap: idle cycle after each accept; mid_start: re-pulse start after that
  // many pixels; rst_after: pull reset after that many pixels and abandon.
  task automatic run_frame(input bit gap, input int mid_start, input int rst_after);
    int p, c, r, cyc;
    bit acc, hit;
    win_cnt = 0; shift_cnt = 0; done_cnt = 0;
    exp_q.delete();
    start = 1'b1;
    tick();
    p = 0;
    while (p < NPIX) begin
      pix_valid = 1'b1;
      pix_in = 8'(p);
      cyc = 0;
      acc = 1'b0;
      while (!acc) begin
        @(negedge clock);
        acc = pix_valid && pix_ready;
        if (!acc) begin
          tick();
          cyc++;
          if (cyc > 200) begin
            chk("accept_timeout", p, -1);
            pix_valid = 1'b0;
            return;
          end
        end
      end
      c = p % W;
      r = p / W;
      hit = (c >= K - 1) && (r >= K - 1);
      if (hit) exp_q.push_back((c - (K - 1)) * 16 + (r - (K - 1)));
      tick();
      if (hit) begin
        chk("win_latency", int'(win_valid), 1);
        chk("win_latency_coord", int'(win_col) * 16 + int'(win_row),
            (c - (K - 1)) * 16 + (r - (K - 1)));
      end
      p++;
      if (p == mid_start) start = 1'b1;
      if (p == rst_after) begin
        reset = 1'b0;
        #1;
        chk("rst_pix_ready", int'(pix_ready), 0);
        chk("rst_shift_en", int'(sr_shift_en), 0);
        chk("rst_win_valid", int'(win_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_coord", int'(win_col) + int'(win_row) + int'(frame_done), 0);
        pix_valid = 1'b0;
        exp_q.delete();
        tick();
        reset = 1'b1;
        tick();
        return;
      end
      if (gap) begin
        pix_valid = 1'b0;
        tick();
      end
    end
    pix_valid = 1'b0;
    cyc = 0;
    while (done_cnt == 0 && cyc < 60) begin
      tick();
      cyc++;
    end
    chk("frame_done_seen", done_cnt, 1);
    tick();
    chk("busy_after_done", int'(busy), 0);
    tick();
    chk("frame_done_once", done_cnt, 1);
    chk("window_count", win_cnt, NWIN);
    chk("scoreboard_empty", exp_q.size(), 0);
    chk("shift_count", shift_cnt, NPIX);
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; pix_valid = 1'b0; pix_in = '0;
    win_cnt = 0; shift_cnt = 0; done_cnt = 0;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b1;
    pix_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      chk("idle_pix_ready", int'(pix_ready), 0);
      chk("idle_shift_en", int'(sr_shift_en), 0);
      chk("idle_win_valid", int'(win_valid), 0);
      chk("idle_busy", int'(busy), 0);
    end
    tick();
    pix_valid = 1'b0;
    tick();

    run_frame(1'b0, -1, -1);   // back-to-back
    stall_req = 1'b1;
    run_frame(1'b0, -1, -1);   // consumer stall at first window
    chk("stall_happened", int'(stall_req), 0);
    run_frame(1'b1, -1, -1);   // pix_valid every other cycle
    run_frame(1'b0, -1, 10);   // reset after 10 pixels
    run_frame(1'b0, -1, -1);   // clean restart after reset
    run_frame(1'b0, 8, -1);    // start re-pulsed mid-frame

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
